mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/rr_arb2.sv | 12 +
 rtl/mem_arb.sv | 122 ++++++++++++
 tb/tb_mem_arb.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared widths and FSM state type for the two-requester memory arbiter.
package pack;

    localparam int ADDRESS_BITS  = 8;
    localparam int DATA_IN_BITS  = 8;
    localparam int DATA_OUT_BITS = DATA_IN_BITS + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WAIT_RD = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: ptr=0 favours req0 on a tie, ptr=1 favours req1.
module rr_arb2 (
    input  logic       req0,
    input  logic       req1,
    input  logic       ptr,
    output logic [1:0] win
);

    assign win[0] = req0 & (~req1 | ~ptr);
    assign win[1] = req1 & (~req0 |  ptr);

endmodule

// File: rtl/mem_arb.sv
// Serialises single accesses from two requesters onto one memory port.
// Optional PARITY_CHECK_EN adds a parity check on read responses.
module mem_arb
    import pack::*;
#(
    parameter int MEM_RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [ADDRESS_BITS-1:0]  addr0,
    input  logic [ADDRESS_BITS-1:0]  addr1,
    input  logic [DATA_IN_BITS-1:0]  wdata0,
    input  logic [DATA_IN_BITS-1:0]  wdata1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     rvalid0,
    output logic                     rvalid1,
    output logic [DATA_IN_BITS-1:0]  rdata,
    output logic                     parity_err,
    output logic                     mem_write,
    output logic                     mem_read,
    output logic [ADDRESS_BITS-1:0]  mem_address,
    output logic [DATA_IN_BITS-1:0]  mem_data_in,
    input  logic [DATA_OUT_BITS-1:0] mem_data_out
);

    localparam logic [1:0] RD_LAST = 2'(MEM_RD_LAT - 1);

    state_t                    state, nxt;
    logic                      ptr;
    logic [1:0]                cnt;
    logic [1:0]                win;
    logic                      cmd_win;
    logic                      cmd_we;
    logic [ADDRESS_BITS-1:0]   cmd_addr;
    logic [DATA_IN_BITS-1:0]   cmd_wdata;
    logic                      rd_last;

    rr_arb2 u_arb (
        .req0 (req0),
        .req1 (req1),
        .ptr  (ptr),
        .win  (win)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            cnt     <= 2'd0;
            cmd_win <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= (state == WAIT_RD) ? cnt + 2'd1 : 2'd0;
            // Pointer moves to the other requester only once its access is issued.
            if (state == ACCESS)
                ptr <= ~cmd_win;
            if (state == IDLE && win != 2'b00)
                cmd_win <= win[1];
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && win != 2'b00) begin
            cmd_we    <= win[1] ? we1    : we0;
            cmd_addr  <= win[1] ? addr1  : addr0;
            cmd_wdata <= win[1] ? wdata1 : wdata0;
        end
    end

    always_comb begin
        nxt         = state;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        rvalid0     = 1'b0;
        rvalid1     = 1'b0;
        rdata       = '0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        mem_address = '0;
        mem_data_in = '0;
        rd_last     = 1'b0;
        case (state)
            IDLE: begin
                if (win != 2'b00)
                    nxt = ACCESS;
            end
            ACCESS: begin
                gnt0        = ~cmd_win;
                gnt1        = cmd_win;
                mem_address = cmd_addr;
                mem_data_in = cmd_wdata;
                mem_write   = cmd_we;
                mem_read    = ~cmd_we;
                nxt         = cmd_we ? IDLE : WAIT_RD;
            end
            WAIT_RD: begin
                if (cnt == RD_LAST) begin
                    rd_last = 1'b1;
                    rvalid0 = ~cmd_win;
                    rvalid1 = cmd_win;
                    rdata   = mem_data_out[DATA_IN_BITS-1:0];
                    nxt     = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

`ifdef PARITY_CHECK_EN
    assign parity_err = rd_last & (^mem_data_out);
`else
    logic unused_parity;
    assign unused_parity = mem_data_out[DATA_IN_BITS] ^ rd_last;
    assign parity_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with a behavioural one-cycle-latency memory.
module tb_mem_arb;
    import pack::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     req0, req1, we0, we1;
    logic [ADDRESS_BITS-1:0]  addr0, addr1;
    logic [DATA_IN_BITS-1:0]  wdata0, wdata1;
    logic                     gnt0, gnt1, rvalid0, rvalid1, parity_err;
    logic [DATA_IN_BITS-1:0]  rdata;
    logic                     mem_write, mem_read;
    logic [ADDRESS_BITS-1:0]  mem_address;
    logic [DATA_IN_BITS-1:0]  mem_data_in;
    logic [DATA_OUT_BITS-1:0] mem_data_out;

    int errors = 0;
    int checks = 0;

    logic [DATA_IN_BITS-1:0]  mem [256];
    logic [ADDRESS_BITS-1:0]  rd_addr = '0;
    logic                     flip = 1'b0;
    logic                     exp_perr;
    logic [30:0]              outs;
    logic [1:0]               rr_exp [8];

    always #5 clk = ~clk;

    mem_arb #(.MEM_RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .parity_err(parity_err),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out)
    );

    // Memory answers one cycle after mem_read, stored with even parity.
    always @(posedge clk) begin
        if (mem_write) mem[mem_address] <= mem_data_in;
        if (mem_read)  rd_addr <= mem_address;
    end
    assign mem_data_out = {(^mem[rd_addr]) ^ flip, mem[rd_addr]};

    assign outs = {gnt0, gnt1, rvalid0, rvalid1, parity_err, mem_write, mem_read,
                   mem_address, mem_data_in, rdata};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef PARITY_CHECK_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        rr_exp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        #3;
        check("reset_outs", 32'(outs), 32'd0);
        tick();
        check("reset_outs_held", 32'(outs), 32'd0);
        rst = 1'b0;

        // Write 0x5A to address 3 from requester 0.
        req0 = 1; we0 = 1; addr0 = 8'd3; wdata0 = 8'h5A;
        tick();
        check("wr_gnt", {30'd0, gnt1, gnt0}, 32'b01);
        check("wr_strobes", {30'd0, mem_write, mem_read}, 32'b10);
        check("wr_addr", 32'(mem_address), 32'd3);
        check("wr_data", 32'(mem_data_in), 32'h5A);
        req0 = 0; we0 = 0;
        tick();
        check("wr_done_idle", 32'(outs), 32'd0);

        // Read address 3 from requester 1.
        req1 = 1; we1 = 0; addr1 = 8'd3;
        tick();
        check("rd_gnt", {30'd0, gnt1, gnt0}, 32'b10);
        check("rd_strobes", {30'd0, mem_write, mem_read}, 32'b01);
        check("rd_addr", 32'(mem_address), 32'd3);
        req1 = 0;
        tick();
        check("rd_rvalid", {30'd0, rvalid1, rvalid0}, 32'b10);
        check("rd_data", 32'(rdata), 32'h5A);
        check("rd_parity_ok", 32'(parity_err), 32'd0);
        check("rd_no_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        tick();
        check("rd_done_idle", 32'(outs), 32'd0);

        // Round robin from a fresh reset with both requesters writing.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0 = 1; we0 = 1; addr0 = 8'd10; wdata0 = 8'h11;
        req1 = 1; we1 = 1; addr1 = 8'd11; wdata1 = 8'h22;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("rr_gnt_%0d", i), {30'd0, gnt1, gnt0}, {30'd0, rr_exp[i]});
            if (rr_exp[i] != 2'b00)
                check($sformatf("rr_wdata_%0d", i), 32'(mem_data_in),
                      rr_exp[i][1] ? 32'h22 : 32'h11);
        end
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;

        // Read address 10 with the parity bit corrupted.
        req0 = 1; addr0 = 8'd10;
        tick();
        check("par_gnt", {30'd0, gnt1, gnt0}, 32'b01);
        req0 = 0;
        flip = 1'b1;
        tick();
        check("par_rvalid", {30'd0, rvalid1, rvalid0}, 32'b01);
        check("par_rdata", 32'(rdata), 32'h11);
        check("par_err", 32'(parity_err), {31'd0, exp_perr});
        flip = 1'b0;
        tick();
        check("par_err_clear", 32'(parity_err), 32'd0);

        // Reset while the read response is pending.
        req1 = 1; addr1 = 8'd11;
        tick();
        check("rst_rd_gnt", {30'd0, gnt1, gnt0}, 32'b10);
        req1 = 0;
        tick();
        check("rst_rd_pending", 32'(rvalid1), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_outs", 32'(outs), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_quiet0", 32'(outs), 32'd0);
        tick();
        check("post_rst_quiet1", 32'(outs), 32'd0);

        // Last written address still reads back correctly.
        req0 = 1; addr0 = 8'd11;
        tick();
        check("post_rst_gnt", {30'd0, gnt1, gnt0}, 32'b01);
        req0 = 0;
        tick();
        check("post_rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'b01);
        check("post_rst_rdata", 32'(rdata), 32'h22);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
